// File: rtl/pic_bus_sequencer.sv
// Bus-master sequencer for an 8259A-style PIC: runs the ICW/OCW init list, services INT with
// the two-pulse INTA handshake, and performs run-time OCW1 mask rewrites.
module pic_bus_sequencer #(
    parameter logic [7:0]  ICW1         = 8'h1B,
    parameter logic [7:0]  ICW2         = 8'hA8,
    parameter logic [7:0]  ICW3         = 8'h00,
    parameter logic [7:0]  ICW4         = 8'h02,
    parameter logic [7:0]  OCW1         = 8'h80,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    input  logic       vec_ack,
    input  logic       pic_int,
    input  logic [7:0] pic_d_in,
    output logic       busy,
    output logic       init_done,
    output logic       pic_cs_n,
    output logic       pic_wr_n,
    output logic       pic_rd_n,
    output logic       pic_a0,
    output logic [7:0] pic_d_out,
    output logic       pic_d_oe,
    output logic       pic_inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_data
);

    typedef enum logic [3:0] {
        StIdle,
        StWSetup,
        StWPulse,
        StWHold,
        StWGap,
        StReady,
        StInta1,
        StIntaGap,
        StInta2,
        StVecWait
    } state_e;

    localparam logic [2:0] WordIcw1 = 3'd0;
    localparam logic [2:0] WordIcw2 = 3'd1;
    localparam logic [2:0] WordIcw3 = 3'd2;
    localparam logic [2:0] WordIcw4 = 3'd3;
    localparam logic [2:0] WordOcw1 = 3'd4;
    localparam logic [2:0] WordDone = 3'd5;

    localparam logic [7:0] PulseLast = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);

    // Skipped words are resolved here so they cost no bus cycles.
    function automatic logic [2:0] next_word(input logic [2:0] idx);
        logic [2:0] nxt;
        case (idx)
            WordIcw1: nxt = WordIcw2;
            WordIcw2: nxt = !ICW1[1] ? WordIcw3 : (ICW1[0] ? WordIcw4 : WordOcw1);
            WordIcw3: nxt = ICW1[0] ? WordIcw4 : WordOcw1;
            WordIcw4: nxt = WordOcw1;
            default:  nxt = WordDone;
        endcase
        return nxt;
    endfunction

    function automatic logic [7:0] word_value(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            WordIcw1: val = ICW1;
            WordIcw2: val = ICW2;
            WordIcw3: val = ICW3;
            WordIcw4: val = ICW4;
            default:  val = OCW1;
        endcase
        return val;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       init_mode_q, init_mode_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_a0_q, wr_a0_d;
    logic [7:0] mask_q, mask_d;
    logic       pend_q, pend_d;
    logic       init_done_q, init_done_d;
    logic       vec_valid_q, vec_valid_d;
    logic [7:0] vec_data_q, vec_data_d;

    logic       launch_init;
    logic [2:0] launch_idx;
    logic [2:0] nxt_word;
    logic [7:0] mask_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            init_mode_q <= 1'b0;
            wr_data_q   <= '0;
            wr_a0_q     <= 1'b0;
            mask_q      <= '0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_mode_q <= init_mode_d;
            wr_data_q   <= wr_data_d;
            wr_a0_q     <= wr_a0_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            vec_valid_q <= vec_valid_d;
            vec_data_q  <= vec_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_mode_d = init_mode_q;
        wr_data_d   = wr_data_q;
        wr_a0_d     = wr_a0_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        init_done_d = init_done_q;
        vec_valid_d = vec_valid_q;
        vec_data_d  = vec_data_q;
        launch_init = 1'b0;
        launch_idx  = WordIcw1;
        nxt_word    = next_word(idx_q);
        // A same-cycle request is newer than anything already latched.
        mask_now    = mask_wr ? mask_data : mask_q;

        if (mask_wr && (state_q != StIdle)) begin
            mask_d = mask_data;
            pend_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    init_mode_d = 1'b1;
                    launch_init = 1'b1;
                end
            end
            StWSetup: begin
                state_d = StWPulse;
                cnt_d   = '0;
            end
            StWPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = StWHold;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWHold: begin
                state_d = StWGap;
                cnt_d   = '0;
            end
            StWGap: begin
                if (cnt_q != GapLast) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!init_mode_q) begin
                    state_d = StReady;
                end else if (nxt_word == WordDone) begin
                    state_d     = StReady;
                    init_mode_d = 1'b0;
                    init_done_d = 1'b1;
                end else begin
                    launch_init = 1'b1;
                    launch_idx  = nxt_word;
                end
            end
            StReady: begin
                if (start) begin
                    init_done_d = 1'b0;
                    init_mode_d = 1'b1;
                    launch_init = 1'b1;
                end else if (pic_int && !vec_valid_q) begin
                    state_d = StInta1;
                    cnt_d   = '0;
                end else if (pend_q) begin
                    state_d   = StWSetup;
                    wr_data_d = mask_now;
                    wr_a0_d   = 1'b1;
                    pend_d    = 1'b0;
                end
            end
            StInta1: begin
                if (cnt_q == PulseLast) begin
                    state_d = StIntaGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIntaGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StInta2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StInta2: begin
                if (cnt_q == PulseLast) begin
                    state_d     = StVecWait;
                    vec_data_d  = pic_d_in;
                    vec_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StVecWait: begin
                if (vec_ack) begin
                    vec_valid_d = 1'b0;
                    state_d     = StReady;
                end
            end
            default: state_d = StIdle;
        endcase

        // The init's final OCW1 absorbs any pending mask so it is not written twice.
        if (launch_init) begin
            state_d = StWSetup;
            idx_d   = launch_idx;
            wr_a0_d = (launch_idx != WordIcw1);
            if (launch_idx == WordOcw1) begin
                wr_data_d = (pend_q || mask_wr) ? mask_now : OCW1;
                pend_d    = 1'b0;
            end else begin
                wr_data_d = word_value(launch_idx);
            end
        end
    end

    always_comb begin
        pic_cs_n   = 1'b1;
        pic_wr_n   = 1'b1;
        pic_d_oe   = 1'b0;
        pic_d_out  = '0;
        pic_a0     = 1'b0;
        pic_inta_n = 1'b1;
        case (state_q)
            StWSetup, StWHold: begin
                pic_cs_n  = 1'b0;
                pic_d_oe  = 1'b1;
                pic_d_out = wr_data_q;
                pic_a0    = wr_a0_q;
            end
            StWPulse: begin
                pic_cs_n  = 1'b0;
                pic_wr_n  = 1'b0;
                pic_d_oe  = 1'b1;
                pic_d_out = wr_data_q;
                pic_a0    = wr_a0_q;
            end
            StInta1, StInta2: pic_inta_n = 1'b0;
            default: ;
        endcase
    end

    assign pic_rd_n  = 1'b1;
    assign busy      = !(state_q inside {StIdle, StReady});
    assign init_done = init_done_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Bench for pic_bus_sequencer: three instances (ICW1 = 1B, 19, 1A) share stimulus; a per-instance
// write monitor pops expected {a0,data} words from a scoreboard queue.
module tb_pic_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mask_wr, vec_ack, pic_int;
    logic [7:0] mask_data, pic_d_in;

    logic       busy_w [3];
    logic       init_done_w [3];
    logic       cs_n_w [3];
    logic       wr_n_w [3];
    logic       rd_n_w [3];
    logic       a0_w [3];
    logic [7:0] d_out_w [3];
    logic       d_oe_w [3];
    logic       inta_n_w [3];
    logic       vec_valid_w [3];
    logic [7:0] vec_data_w [3];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]      nwords;
        logic [4:0][8:0] words;
        logic [7:0]      done_cyc;
    } init_vec_t;

    init_vec_t tbl [3];
    int        done_n [3];

    always #5 clk = ~clk;

    pic_bus_sequencer #(.ICW1(8'h1B)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mask_wr(mask_wr), .mask_data(mask_data),
        .vec_ack(vec_ack), .pic_int(pic_int), .pic_d_in(pic_d_in), .busy(busy_w[0]),
        .init_done(init_done_w[0]), .pic_cs_n(cs_n_w[0]), .pic_wr_n(wr_n_w[0]),
        .pic_rd_n(rd_n_w[0]), .pic_a0(a0_w[0]), .pic_d_out(d_out_w[0]), .pic_d_oe(d_oe_w[0]),
        .pic_inta_n(inta_n_w[0]), .vec_valid(vec_valid_w[0]), .vec_data(vec_data_w[0])
    );

    pic_bus_sequencer #(.ICW1(8'h19)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mask_wr(mask_wr), .mask_data(mask_data),
        .vec_ack(vec_ack), .pic_int(pic_int), .pic_d_in(pic_d_in), .busy(busy_w[1]),
        .init_done(init_done_w[1]), .pic_cs_n(cs_n_w[1]), .pic_wr_n(wr_n_w[1]),
        .pic_rd_n(rd_n_w[1]), .pic_a0(a0_w[1]), .pic_d_out(d_out_w[1]), .pic_d_oe(d_oe_w[1]),
        .pic_inta_n(inta_n_w[1]), .vec_valid(vec_valid_w[1]), .vec_data(vec_data_w[1])
    );

    pic_bus_sequencer #(.ICW1(8'h1A)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mask_wr(mask_wr), .mask_data(mask_data),
        .vec_ack(vec_ack), .pic_int(pic_int), .pic_d_in(pic_d_in), .busy(busy_w[2]),
        .init_done(init_done_w[2]), .pic_cs_n(cs_n_w[2]), .pic_wr_n(wr_n_w[2]),
        .pic_rd_n(rd_n_w[2]), .pic_a0(a0_w[2]), .pic_d_out(d_out_w[2]), .pic_d_oe(d_oe_w[2]),
        .pic_inta_n(inta_n_w[2]), .vec_valid(vec_valid_w[2]), .vec_data(vec_data_w[2])
    );

    // A write completes when wr_n rises while cs_n is still low.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic [8:0] exp_q [$];
        logic [8:0] w;
        int         low_cnt = 0;
        bit         was_low = 1'b0;
        always @(negedge clk) begin
            if (!cs_n_w[g] && !wr_n_w[g]) begin
                low_cnt++;
            end else if (was_low && !cs_n_w[g] && wr_n_w[g]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr%0d_unexpected: got a0=%0b d=%02h, required no write",
                             g, a0_w[g], d_out_w[g]);
                end else begin
                    w = exp_q.pop_front();
                    if ({a0_w[g], d_out_w[g]} !== w || low_cnt != 2 || d_oe_w[g] !== 1'b1) begin
                        failures++;
                        $display("FAIL wr%0d_word: got a0=%0b d=%02h low=%0d oe=%0b, required a0=%0b d=%02h low=2 oe=1",
                                 g, a0_w[g], d_out_w[g], low_cnt, d_oe_w[g], w[8], w[7:0]);
                    end
                end
                low_cnt = 0;
            end else begin
                low_cnt = 0;
            end
            was_low = !cs_n_w[g] && !wr_n_w[g];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [8:0] w);
        case (k)
            0:       g_mon[0].exp_q.push_back(w);
            1:       g_mon[1].exp_q.push_back(w);
            default: g_mon[2].exp_q.push_back(w);
        endcase
    endtask

    function automatic int exp_left(input int k);
        case (k)
            0:       return g_mon[0].exp_q.size();
            1:       return g_mon[1].exp_q.size();
            default: return g_mon[2].exp_q.size();
        endcase
    endfunction

    task automatic push_init(input logic [7:0] ocw1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < int'(tbl[k].nwords) - 1; i++) push_exp(k, tbl[k].words[i]);
            push_exp(k, {1'b1, ocw1});
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_init(input int max_n, input int mask_n, input logic [7:0] mask_val);
        for (int k = 0; k < 3; k++) done_n[k] = -1;
        for (int n = 1; n <= max_n; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (done_n[k] < 0 && init_done_w[k]) done_n[k] = n;
            mask_wr   = (n == mask_n);
            mask_data = mask_val;
        end
        mask_wr = 1'b0;
    endtask

    task automatic check_init_results(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_done_cyc%0d", tag, k), done_n[k], int'(tbl[k].done_cyc));
            check($sformatf("%s_left%0d", tag, k), exp_left(k), 0);
            check($sformatf("%s_busy%0d", tag, k), busy_w[k], 0);
        end
    endtask

    initial begin
        int inta_pat [6] = '{0, 0, 1, 0, 0, 1};
        int vv_pat [6]   = '{0, 0, 0, 0, 0, 1};

        tbl[0].nwords = 3'd4; tbl[0].done_cyc = 8'd20;
        tbl[0].words[0] = 9'h01B; tbl[0].words[1] = 9'h1A8; tbl[0].words[2] = 9'h102;
        tbl[0].words[3] = 9'h180; tbl[0].words[4] = 9'h000;
        tbl[1].nwords = 3'd5; tbl[1].done_cyc = 8'd25;
        tbl[1].words[0] = 9'h019; tbl[1].words[1] = 9'h1A8; tbl[1].words[2] = 9'h100;
        tbl[1].words[3] = 9'h102; tbl[1].words[4] = 9'h180;
        tbl[2].nwords = 3'd3; tbl[2].done_cyc = 8'd15;
        tbl[2].words[0] = 9'h01A; tbl[2].words[1] = 9'h1A8; tbl[2].words[2] = 9'h180;
        tbl[2].words[3] = 9'h000; tbl[2].words[4] = 9'h000;

        rst_n = 1'b0; start = 1'b0; mask_wr = 1'b0; vec_ack = 1'b0; pic_int = 1'b0;
        mask_data = 8'h00; pic_d_in = 8'h00;
        #3;
        check("rst_cs_n", cs_n_w[0], 1);
        check("rst_wr_n", wr_n_w[0], 1);
        check("rst_rd_n", rd_n_w[0], 1);
        check("rst_inta_n", inta_n_w[0], 1);
        check("rst_oe_a0_d", {d_oe_w[0], a0_w[0], d_out_w[0]}, 0);
        check("rst_status", {busy_w[0], init_done_w[0], vec_valid_w[0], vec_data_w[0]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default init plus ICW3/ICW4 skip variants.
        push_init(8'h80);
        do_start();
        check("start_busy", busy_w[0], 1);
        wait_init(30, 0, 8'h00);
        check_init_results("init");

        // INTA with a same-cycle mask request; INT drops mid-sequence.
        @(negedge clk);
        pic_int = 1'b1; mask_wr = 1'b1; mask_data = 8'h0F; pic_d_in = 8'hAB;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check($sformatf("inta_n_c%0d", n), inta_n_w[0], inta_pat[n-1]);
            check($sformatf("inta_vv_c%0d", n), vec_valid_w[0], vv_pat[n-1]);
            check($sformatf("inta_cs_c%0d", n), cs_n_w[0], 1);
            if (n == 1) begin
                mask_wr = 1'b0;
                pic_int = 1'b0;
            end
        end
        pic_d_in = 8'h00;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("vec_hold_valid", vec_valid_w[0], 1);
            check("vec_hold_cs", cs_n_w[0], 1);
        end
        check("vec_data", vec_data_w[0], 8'hAB);
        for (int k = 0; k < 3; k++) push_exp(k, 9'h10F);
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        check("vec_ack_clear", vec_valid_w[0], 0);
        check("vec_data_kept", vec_data_w[0], 8'hAB);
        for (int n = 0; n < 20 && exp_left(0) != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("mask_left%0d", k), exp_left(k), 0);
        check("mask_ready", {busy_w[0], init_done_w[0]}, 2'b01);

        // Stray ack in READY.
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        @(negedge clk);
        check("stray_ack", {busy_w[0], vec_valid_w[0], vec_data_w[0]}, 10'h0AB);

        // Re-init, ignored start while busy, then reset during the ICW2 pulse.
        for (int k = 0; k < 3; k++) push_exp(k, tbl[k].words[0]);
        do_start();
        check("reinit_done_clr", init_done_w[0], 0);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = (n == 2);
        end
        check("icw2_pulse", {wr_n_w[0], a0_w[0], d_out_w[0]}, {1'b0, 1'b1, 8'hA8});
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {cs_n_w[0], wr_n_w[0], d_oe_w[0]}, 3'b110);
        check("rst_mid_status", {busy_w[0], init_done_w[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_idle", {busy_w[0], init_done_w[0], cs_n_w[0]}, 3'b001);
        for (int k = 0; k < 3; k++) check($sformatf("rst_left%0d", k), exp_left(k), 0);

        // mask_wr in IDLE must not reach the init OCW1.
        mask_wr = 1'b1; mask_data = 8'h33;
        @(negedge clk);
        mask_wr = 1'b0;
        push_init(8'h80);
        do_start();
        wait_init(30, 0, 8'h00);
        check_init_results("idle_mask");
        repeat (10) @(negedge clk);

        // mask_wr during init replaces the final OCW1 and is not written again.
        push_init(8'h5A);
        do_start();
        wait_init(30, 3, 8'h5A);
        check_init_results("mid_mask");
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("final_left%0d", k), exp_left(k), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
